set_scan_ctrl: RTL



---
 rtl/set_scan_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/set_scan_ctrl.sv
// set_scan_ctrl: job controller for the circle-coverage processing element.
// Latches one job (three centres, three radii, a mode), then sweeps the 8x8
// grid one point per cycle. Each point and the buffered circle data go to
// the PE. The returned A/B/C coverage flags are combined according to the
// mode, and the qualifying points are counted.
//
// Ports:
//   clk_i        clock
//   rst_i        asynchronous active-high reset
//   en_i         job start, sampled only while idle
//   central_i    centres {A_X,A_Y,B_X,B_Y,C_X,C_Y}, 4 bits each
//   radius_i     radii {A_R,B_R,C_R}, 4 bits each
//   mode_i       set expression select
//   covered_i    PE coverage flags {A,B,C} for the current coord_o
//   coord_o      current grid point {X,Y}, each 1..8
//   cent_buf_o   latched centres, to the PE
//   r_buf_o      latched radii, to the PE
//   busy_o       job in progress
//   valid_o      one-cycle pulse when candidate_o is final
//   candidate_o  number of qualifying points, 0..64
module set_scan_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic [23:0] central_i,
    input  logic [11:0] radius_i,
    input  logic [1:0]  mode_i,
    input  logic [2:0]  covered_i,
    output logic [7:0]  coord_o,
    output logic [23:0] cent_buf_o,
    output logic [11:0] r_buf_o,
    output logic        busy_o,
    output logic        valid_o,
    output logic [7:0]  candidate_o
);

    localparam int unsigned AXIS_W = 4;
    localparam int unsigned CNT_W  = 7;
    localparam int unsigned MODE_W = 2;

    localparam logic [AXIS_W-1:0] AXIS_FIRST = AXIS_W'(1);
    localparam logic [AXIS_W-1:0] AXIS_LAST  = AXIS_W'(8);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [23:0]         cent_q, cent_d;
    logic [11:0]         r_q, r_d;
    logic [MODE_W-1:0]   mode_q, mode_d;
    logic [AXIS_W-1:0]   x_q, x_d;
    logic [AXIS_W-1:0]   y_q, y_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                busy_q, busy_d;
    logic                valid_q, valid_d;
    logic                qualify_c;

    // Set expression over the PE flags for the point currently presented
    always_comb begin
        logic a, b, c;
        a = covered_i[2];
        b = covered_i[1];
        c = covered_i[0];
        qualify_c = 1'b0;
        case (mode_q)
            2'd0:    qualify_c = a;
            2'd1:    qualify_c = a & b;
            2'd2:    qualify_c = a ^ b;
            default: qualify_c = ((a & b) | (b & c) | (a & c)) & ~(a & b & c);
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cent_q  <= '0;
            r_q     <= '0;
            mode_q  <= '0;
            x_q     <= AXIS_FIRST;
            y_q     <= AXIS_FIRST;
            count_q <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cent_q  <= cent_d;
            r_q     <= r_d;
            mode_q  <= mode_d;
            x_q     <= x_d;
            y_q     <= y_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    // Next-state logic; buffers and coord hold unless accepting or stepping
    always_comb begin
        state_d = state_q;
        cent_d  = cent_q;
        r_d     = r_q;
        mode_d  = mode_q;
        x_d     = x_q;
        y_d     = y_q;
        count_d = count_q;
        busy_d  = 1'b0;
        valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (en_i) begin
                    cent_d  = central_i;
                    r_d     = radius_i;
                    mode_d  = mode_i;
                    x_d     = AXIS_FIRST;
                    y_d     = AXIS_FIRST;
                    count_d = '0;
                    busy_d  = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                busy_d  = 1'b1;
                count_d = count_q + CNT_W'(qualify_c);
                // Y is the fast axis; coord stays at (8,8) once the sweep ends
                if (x_q == AXIS_LAST && y_q == AXIS_LAST) begin
                    valid_d = 1'b1;
                    state_d = DONE;
                end else if (y_q == AXIS_LAST) begin
                    y_d = AXIS_FIRST;
                    x_d = x_q + AXIS_W'(1);
                end else begin
                    y_d = y_q + AXIS_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign coord_o     = {x_q, y_q};
    assign cent_buf_o  = cent_q;
    assign r_buf_o     = r_q;
    assign busy_o      = busy_q;
    assign valid_o     = valid_q;
    assign candidate_o = {1'b0, count_q};

endmodule
